// File: rtl/fifo_pkg.sv
// Shared width helpers and round-robin pointer arithmetic for fifo_mux_rr.
package fifo_pkg;

    // Ceiling log2, valid for v >= 1 (returns 0 for v == 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Occupancy counter width: must hold 0..L inclusive.
    function automatic int cw_of(input int l);
        return clog2(l + 1);
    endfunction

    // Channel id width, never narrower than one bit.
    function automatic int iw_of(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Priority pointer after serving channel g: the next channel in cyclic order.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/fifo_chan.sv
// One input channel: circular buffer of L words with occupancy count.
// FIFO_BYPASS_EN: an empty channel with a pending write presents that word
// as its head so it can leave in the same cycle without touching storage.
module fifo_chan
    import fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int L  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_in,
    input  logic          req_in,
    output logic          ack_in,
    output logic [DW-1:0] head,
    output logic          head_vld,
    input  logic          rd,
    output logic [CW-1:0] cnt
);

    localparam int PW = clog2(L);

    logic [DW-1:0] mem_q [L];
    logic [DW-1:0] mem_d [L];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, empty, wr, rd_mem, byp_take;

    // Full is judged on the registered count only, so a read this cycle
    // does not open ack_in until the next one.
    assign full   = (cnt_q == CW'(L));
    assign empty  = (cnt_q == '0);
    assign ack_in = ~full;
    assign cnt    = cnt_q;

`ifdef FIFO_BYPASS_EN
    // A word accepted straight through while empty is never stored.
    assign byp_take = rd & empty;
    assign head_vld = ~empty | req_in;
    assign head     = empty ? d_in : mem_q[rp_q];
`else
    assign byp_take = 1'b0;
    assign head_vld = ~empty;
    assign head     = mem_q[rp_q];
`endif

    assign wr     = req_in & ~full & ~byp_take;
    assign rd_mem = rd & ~empty;

    // Next-state for storage, pointers and count; write and read are independent.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (wr) begin
            mem_d[wp_q] = d_in;
            wp_d        = (wp_q == PW'(L - 1)) ? '0 : wp_q + 1'b1;
        end
        if (rd_mem) begin
            rp_d = (rp_q == PW'(L - 1)) ? '0 : rp_q + 1'b1;
        end
        case ({wr, rd_mem})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset drops any buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array, deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fifo_mux_rr.sv
// fifo_mux_rr: NCH req/ack FIFO channels merged onto one stream by a
// round-robin arbiter. A stalled output locks the grant until accepted.
// Optional macro FIFO_BYPASS_EN enables zero-cycle pass-through for empty
// channels; without it the minimum in->out latency is one cycle.
module fifo_mux_rr
    import fifo_pkg::*;
#(
    parameter  int DW  = 8,
    parameter  int L   = 4,
    parameter  int NCH = 4,
    localparam int CW  = cw_of(L),
    localparam int IW  = iw_of(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] d_in,
    input  logic [NCH-1:0]    req_in,
    output logic [NCH-1:0]    ack_in,
    output logic [DW-1:0]     d_out,
    output logic [IW-1:0]     ch_out,
    output logic              req_out,
    input  logic              ack_out,
    output logic [NCH*CW-1:0] cnt
);

    logic [NCH-1:0][DW-1:0] head;
    logic [NCH-1:0]         head_vld;
    logic [NCH-1:0]         rd;

    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] lch_q, lch_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] gnt, idx;
    logic          found, xfer;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        fifo_chan #(
            .DW (DW),
            .L  (L),
            .CW (CW)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .d_in     (d_in[c*DW +: DW]),
            .req_in   (req_in[c]),
            .ack_in   (ack_in[c]),
            .head     (head[c]),
            .head_vld (head_vld[c]),
            .rd       (rd[c]),
            .cnt      (cnt[c*CW +: CW])
        );
    end

    // Grant: the held channel while locked, else first valid channel from rr.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        if (lock_q) begin
            gnt   = lch_q;
            found = head_vld[lch_q];
        end else begin
            for (int i = 0; i < NCH; i++) begin
                idx = IW'((int'(rr_q) + i) % NCH);
                if (!found && head_vld[idx]) begin
                    found = 1'b1;
                    gnt   = idx;
                end
            end
        end
    end

    assign req_out = found;
    assign d_out   = found ? head[gnt] : '0;
    assign ch_out  = found ? gnt : '0;
    assign xfer    = found & ack_out;

    // Pop strobe to the granted channel on an output transfer.
    always_comb begin
        rd = '0;
        if (xfer) rd[gnt] = 1'b1;
    end

    // Priority pointer advances past the served channel; lock tracks stalls.
    always_comb begin
        rr_d   = xfer ? IW'(rr_next(int'(gnt), NCH)) : rr_q;
        lock_d = found & ~ack_out;
        lch_d  = lock_d ? gnt : lch_q;
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            lch_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            lch_q  <= lch_d;
        end
    end

endmodule

// File: tb/tb_fifo_mux_rr.sv
// Self-checking bench for fifo_mux_rr (DW=8, L=4, NCH=4). Directed scenarios
// use hand-written expected values; a queue-per-channel model drives the
// randomized run.
module tb_fifo_mux_rr;

    localparam int DW  = 8;
    localparam int L   = 4;
    localparam int NCH = 4;
    localparam int CW  = 3;
    localparam int IW  = 2;
`ifdef FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] d_in;
    logic [NCH-1:0]    req_in;
    logic [NCH-1:0]    ack_in;
    logic [DW-1:0]     d_out;
    logic [IW-1:0]     ch_out;
    logic              req_out;
    logic              ack_out;
    logic [NCH*CW-1:0] cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_mux_rr #(.DW(DW), .L(L), .NCH(NCH)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .req_in  (req_in),
        .ack_in  (ack_in),
        .d_out   (d_out),
        .ch_out  (ch_out),
        .req_out (req_out),
        .ack_out (ack_out),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel plus arbitration bookkeeping.
    logic [DW-1:0] mq [NCH][$];
    int            m_rr   = 0;
    bit            m_lock = 1'b0;
    int            m_lch  = 0;

    // Expectations for the current cycle, filled in by apply().
    bit                e_req;
    int                e_g;
    logic [DW-1:0]     e_d;
    logic [NCH-1:0]    e_ack;
    logic [NCH*CW-1:0] e_cnt;

    function automatic bit cand(input int c);
        return (mq[c].size() != 0) || (BYP && req_in[c]);
    endfunction

    // Drive inputs for this cycle and work out what the outputs should be.
    task automatic apply(input logic [NCH-1:0] r, input logic [NCH*DW-1:0] d, input logic a);
        req_in  = r;
        d_in    = d;
        ack_out = a;
        #1;
        for (int c = 0; c < NCH; c++) begin
            e_ack[c]          = (mq[c].size() != L);
            e_cnt[c*CW +: CW] = CW'(mq[c].size());
        end
        e_req = 1'b0;
        e_g   = 0;
        if (m_lock) begin
            e_g   = m_lch;
            e_req = cand(m_lch);
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!e_req && cand((m_rr + i) % NCH)) begin
                    e_req = 1'b1;
                    e_g   = (m_rr + i) % NCH;
                end
            end
        end
        if (!e_req)                 e_d = '0;
        else if (mq[e_g].size() != 0) e_d = mq[e_g][0];
        else                        e_d = d_in[e_g*DW +: DW];
    endtask

    // Clock edge: update the model with what the edge should have done.
    task automatic advance();
        bit x, byp;
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_rr   = 0;
            m_lock = 1'b0;
            m_lch  = 0;
        end else begin
            x   = e_req && ack_out;
            byp = x && (mq[e_g].size() == 0);
            if (x && !byp) void'(mq[e_g].pop_front());
            for (int c = 0; c < NCH; c++)
                if (req_in[c] && e_ack[c] && !(byp && c == e_g))
                    mq[c].push_back(d_in[c*DW +: DW]);
            if (x) m_rr = (e_g + 1) % NCH;
            m_lock = e_req && !ack_out;
            m_lch  = e_g;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply('0, '0, 1'b0);
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(4'b1111, 32'hDEADBEEF, 1'b1);
        advance();
        apply(4'b1111, 32'h12345678, 1'b0);
        advance();
        rst = 1'b0;
        apply('0, '0, 1'b0);
        tests_run++; if (req_out !== 1'b0) begin tests_failed++; $display("FAIL reset_req_out got %0b want 0", req_out); end
        tests_run++; if (d_out !== 8'h00) begin tests_failed++; $display("FAIL reset_d_out got %h want 00", d_out); end
        tests_run++; if (ch_out !== 2'd0) begin tests_failed++; $display("FAIL reset_ch_out got %0d want 0", ch_out); end
        tests_run++; if (ack_in !== 4'b1111) begin tests_failed++; $display("FAIL reset_ack_in got %b want 1111", ack_in); end
        tests_run++; if (cnt !== '0) begin tests_failed++; $display("FAIL reset_cnt got %h want 0", cnt); end
        advance();
    endtask

    task automatic test_single_ch();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = 8'(8'h11 * (i + 1));
            apply(4'b0100, {8'h00, v, 16'h0000}, 1'b0);
            advance();
        end
        apply('0, '0, 1'b0);
        tests_run++; if (cnt[2*CW +: CW] !== 3'd4) begin tests_failed++; $display("FAIL single_cnt2 got %0d want 4", cnt[2*CW +: CW]); end
        tests_run++; if (ack_in[2] !== 1'b0) begin tests_failed++; $display("FAIL single_ack_in2 got %0b want 0", ack_in[2]); end
        tests_run++; if (req_out !== 1'b1 || d_out !== 8'h11) begin tests_failed++; $display("FAIL single_stall got req=%0b d=%h want req=1 d=11", req_out, d_out); end
        advance();
        for (int i = 0; i < 4; i++) begin
            v = 8'(8'h11 * (i + 1));
            apply('0, '0, 1'b1);
            tests_run++; if (req_out !== 1'b1 || d_out !== v || ch_out !== 2'd2) begin tests_failed++; $display("FAIL single_drain%0d got req=%0b d=%h ch=%0d want req=1 d=%h ch=2", i, req_out, d_out, ch_out, v); end
            advance();
        end
        apply('0, '0, 1'b0);
        tests_run++; if (req_out !== 1'b0 || cnt !== '0) begin tests_failed++; $display("FAIL single_empty got req=%0b cnt=%h want req=0 cnt=0", req_out, cnt); end
        advance();
    endtask

    task automatic test_round_robin();
        logic [7:0] ex_d [4];
        logic [1:0] ex_c [4];
        ex_d = '{8'hA0, 8'hB0, 8'hD0, 8'hA1};
        ex_c = '{2'd0, 2'd1, 2'd3, 2'd0};
        do_reset();
        apply(4'b1011, {8'hD0, 8'h00, 8'hB0, 8'hA0}, 1'b0);
        advance();
        apply(4'b0001, {24'h0, 8'hA1}, 1'b0);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply('0, '0, 1'b1);
            tests_run++; if (d_out !== ex_d[i] || ch_out !== ex_c[i]) begin tests_failed++; $display("FAIL rr_order%0d got d=%h ch=%0d want d=%h ch=%0d", i, d_out, ch_out, ex_d[i], ex_c[i]); end
            advance();
        end
        apply('0, '0, 1'b1);
        tests_run++; if (req_out !== 1'b0) begin tests_failed++; $display("FAIL rr_empty got req=%0b want 0", req_out); end
        advance();
    endtask

    task automatic test_lock();
        do_reset();
        apply(4'b0010, {16'h0, 8'hC1, 8'h00}, 1'b0);
        advance();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) apply(4'b0001, {24'h0, 8'hC0}, 1'b0);
            else        apply('0, '0, 1'b0);
            tests_run++; if (req_out !== 1'b1 || d_out !== 8'hC1 || ch_out !== 2'd1) begin tests_failed++; $display("FAIL lock_hold%0d got req=%0b d=%h ch=%0d want req=1 d=c1 ch=1", k, req_out, d_out, ch_out); end
            advance();
        end
        apply('0, '0, 1'b1);
        tests_run++; if (d_out !== 8'hC1 || ch_out !== 2'd1) begin tests_failed++; $display("FAIL lock_accept got d=%h ch=%0d want d=c1 ch=1", d_out, ch_out); end
        advance();
        apply('0, '0, 1'b1);
        tests_run++; if (d_out !== 8'hC0 || ch_out !== 2'd0) begin tests_failed++; $display("FAIL lock_next got d=%h ch=%0d want d=c0 ch=0", d_out, ch_out); end
        advance();
    endtask

    task automatic test_full_read();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = 8'(i + 1);
            apply(4'b0001, {24'h0, v}, 1'b0);
            advance();
        end
        apply(4'b0001, {24'h0, 8'h05}, 1'b0);
        tests_run++; if (cnt[CW-1:0] !== 3'd4 || ack_in[0] !== 1'b0) begin tests_failed++; $display("FAIL full_stall got cnt0=%0d ack0=%0b want 4 0", cnt[CW-1:0], ack_in[0]); end
        advance();
        apply(4'b0001, {24'h0, 8'h05}, 1'b1);
        tests_run++; if (ack_in[0] !== 1'b0 || cnt[CW-1:0] !== 3'd4 || d_out !== 8'h01) begin tests_failed++; $display("FAIL full_pop got ack0=%0b cnt0=%0d d=%h want 0 4 01", ack_in[0], cnt[CW-1:0], d_out); end
        advance();
        apply(4'b0001, {24'h0, 8'h05}, 1'b0);
        tests_run++; if (cnt[CW-1:0] !== 3'd3 || ack_in[0] !== 1'b1) begin tests_failed++; $display("FAIL full_freed got cnt0=%0d ack0=%0b want 3 1", cnt[CW-1:0], ack_in[0]); end
        advance();
        apply('0, '0, 1'b0);
        tests_run++; if (cnt[CW-1:0] !== 3'd4 || ack_in[0] !== 1'b0) begin tests_failed++; $display("FAIL full_refill got cnt0=%0d ack0=%0b want 4 0", cnt[CW-1:0], ack_in[0]); end
        advance();
        for (int i = 0; i < 4; i++) begin
            v = 8'(i + 2);
            apply('0, '0, 1'b1);
            tests_run++; if (d_out !== v) begin tests_failed++; $display("FAIL full_drain%0d got %h want %h", i, d_out, v); end
            advance();
        end
        apply(4'b0001, {24'h0, 8'h06}, 1'b0);
        advance();
        apply(4'b0001, {24'h0, 8'h07}, 1'b1);
        tests_run++; if (cnt[CW-1:0] !== 3'd1 || d_out !== 8'h06) begin tests_failed++; $display("FAIL wr_rd_same got cnt0=%0d d=%h want 1 06", cnt[CW-1:0], d_out); end
        advance();
        apply('0, '0, 1'b1);
        tests_run++; if (cnt[CW-1:0] !== 3'd1 || d_out !== 8'h07) begin tests_failed++; $display("FAIL wr_rd_after got cnt0=%0d d=%h want 1 07", cnt[CW-1:0], d_out); end
        advance();
        apply('0, '0, 1'b0);
        tests_run++; if (cnt[CW-1:0] !== 3'd0) begin tests_failed++; $display("FAIL wr_rd_empty got cnt0=%0d want 0", cnt[CW-1:0]); end
        advance();
    endtask

    task automatic test_bypass();
        do_reset();
        apply(4'b1000, {8'h5A, 24'h0}, 1'b1);
`ifdef FIFO_BYPASS_EN
        tests_run++; if (req_out !== 1'b1 || d_out !== 8'h5A || ch_out !== 2'd3) begin tests_failed++; $display("FAIL bypass_same got req=%0b d=%h ch=%0d want 1 5a 3", req_out, d_out, ch_out); end
        tests_run++; if (cnt[3*CW +: CW] !== 3'd0) begin tests_failed++; $display("FAIL bypass_cnt3 got %0d want 0", cnt[3*CW +: CW]); end
        advance();
        apply('0, '0, 1'b1);
        tests_run++; if (req_out !== 1'b0 || cnt[3*CW +: CW] !== 3'd0) begin tests_failed++; $display("FAIL bypass_after got req=%0b cnt3=%0d want 0 0", req_out, cnt[3*CW +: CW]); end
        advance();
`else
        tests_run++; if (req_out !== 1'b0 || cnt[3*CW +: CW] !== 3'd0) begin tests_failed++; $display("FAIL nobyp_same got req=%0b cnt3=%0d want 0 0", req_out, cnt[3*CW +: CW]); end
        advance();
        apply('0, '0, 1'b1);
        tests_run++; if (req_out !== 1'b1 || d_out !== 8'h5A || ch_out !== 2'd3) begin tests_failed++; $display("FAIL nobyp_next got req=%0b d=%h ch=%0d want 1 5a 3", req_out, d_out, ch_out); end
        tests_run++; if (cnt[3*CW +: CW] !== 3'd1) begin tests_failed++; $display("FAIL nobyp_cnt3 got %0d want 1", cnt[3*CW +: CW]); end
        advance();
        apply('0, '0, 1'b0);
        tests_run++; if (req_out !== 1'b0 || cnt[3*CW +: CW] !== 3'd0) begin tests_failed++; $display("FAIL nobyp_after got req=%0b cnt3=%0d want 0 0", req_out, cnt[3*CW +: CW]); end
        advance();
`endif
    endtask

    task automatic test_random();
        logic [NCH-1:0] r;
        logic           a;
        int             errs;
        errs = 0;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 149) == 0);
            r   = NCH'($urandom);
            a   = ((k % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            apply(r, $urandom, a);
            tests_run++;
            if (req_out !== e_req || d_out !== e_d || ch_out !== (e_req ? IW'(e_g) : '0) ||
                ack_in !== e_ack || cnt !== e_cnt) begin
                tests_failed++;
                if (errs < 10)
                    $display("FAIL random_cyc%0d got req=%0b d=%h ch=%0d ack=%b cnt=%h want req=%0b d=%h ch=%0d ack=%b cnt=%h",
                             k, req_out, d_out, ch_out, ack_in, cnt, e_req, e_d, e_req ? e_g : 0, e_ack, e_cnt);
                errs++;
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req_in  = '0;
        d_in    = '0;
        ack_out = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_ch();
        test_round_robin();
        test_lock();
        test_full_read();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
